// File: rtl/layered_objects_mux.sv
// N-layer priority pixel mux (layer 0 on top, background below all) with a transparent key,
// per-layer enable and a PLAY/FADE/END screen FSM. Define OBJMUX_FADE_EN to build the fade stage.
module layered_objects_mux #(
    parameter int         NUM_LAYERS      = 8,
    parameter logic [7:0] TRANSPARENT_RGB = 8'hFF,
    parameter int         FRAMES_PER_STEP = 8
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [NUM_LAYERS-1:0]   layerDrawReq,
    input  logic [NUM_LAYERS*8-1:0] layerRGB,
    input  logic [NUM_LAYERS-1:0]   layerEnable,
    input  logic [7:0]              bgRGB,
    input  logic [7:0]              endRGB,
    input  logic                    startOfFrame,
    input  logic                    gameOver,
    input  logic                    restart,
    output logic [7:0]              RGBOut,
    output logic [3:0]              winLayer,
    output logic                    winValid,
    output logic [1:0]              screenState
);

    typedef enum logic [1:0] {
        S_PLAY = 2'b00,
        S_FADE = 2'b01,
        S_END  = 2'b10
    } screen_state_t;

    screen_state_t state, next_state;

    logic       hit_any;
    logic [3:0] hit_idx;
    logic [7:0] hit_rgb;
    logic [7:0] play_rgb;

    // Scan bottom-up so the lowest-index hit is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = 4'd0;
        hit_rgb = 8'd0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layerDrawReq[i] && layerEnable[i] &&
                (layerRGB[8*i +: 8] != TRANSPARENT_RGB)) begin
                hit_any = 1'b1;
                hit_idx = 4'(i);
                hit_rgb = layerRGB[8*i +: 8];
            end
        end
    end

    assign play_rgb = hit_any ? hit_rgb : bgRGB;

`ifdef OBJMUX_FADE_EN
    logic [1:0] fade_lvl;
    logic [7:0] frame_cnt;
    logic       step_done;

    assign step_done = startOfFrame && (frame_cnt == 8'(FRAMES_PER_STEP - 1));

    function automatic logic [7:0] darken(input logic [7:0] c, input logic [1:0] lvl);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = c[7:5] >> lvl;
        g = c[4:2] >> lvl;
        b = c[1:0] >> lvl;
        return {r, g, b};
    endfunction

    // Counters only run while staying in FADE, so they are clear on entry and after exit.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fade_lvl  <= 2'd0;
            frame_cnt <= 8'd0;
        end else if (state != S_FADE || next_state != S_FADE) begin
            fade_lvl  <= 2'd0;
            frame_cnt <= 8'd0;
        end else if (step_done) begin
            frame_cnt <= 8'd0;
            if (fade_lvl != 2'd3) fade_lvl <= fade_lvl + 2'd1;
        end else if (startOfFrame) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= S_PLAY;
        else         state <= next_state;
    end

    // gameOver outranks restart in every state.
    always_comb begin
        next_state = state;
        case (state)
            S_PLAY: begin
`ifdef OBJMUX_FADE_EN
                if (gameOver) next_state = S_FADE;
`else
                if (gameOver) next_state = S_END;
`endif
            end
`ifdef OBJMUX_FADE_EN
            S_FADE: begin
                if (restart && !gameOver)              next_state = S_PLAY;
                else if (fade_lvl == 2'd3 && step_done) next_state = S_END;
            end
`endif
            S_END: begin
                if (restart && !gameOver) next_state = S_PLAY;
            end
            default: next_state = S_PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBOut   <= 8'd0;
            winLayer <= 4'd0;
            winValid <= 1'b0;
        end else begin
            case (state)
                S_END: begin
                    RGBOut   <= endRGB;
                    winLayer <= 4'd0;
                    winValid <= 1'b0;
                end
`ifdef OBJMUX_FADE_EN
                S_FADE: begin
                    RGBOut   <= darken(play_rgb, fade_lvl);
                    winLayer <= hit_idx;
                    winValid <= hit_any;
                end
`endif
                default: begin
                    RGBOut   <= play_rgb;
                    winLayer <= hit_idx;
                    winValid <= hit_any;
                end
            endcase
        end
    end

    assign screenState = state;

endmodule

// File: tb/tb_layered_objects_mux.sv
// Bench for layered_objects_mux: 1-, 8- and 16-layer instances share one stimulus stream;
// the screen FSM is exercised on the 8-layer instance (with or without OBJMUX_FADE_EN).
module tb_layered_objects_mux;

    localparam int FPS = 2;

    logic         clk;
    logic         resetN;
    logic [15:0]  req;
    logic [15:0]  en;
    logic [127:0] rgb;
    logic [7:0]   bg_rgb;
    logic [7:0]   end_rgb;
    logic         sof;
    logic         game_over;
    logic         restart;

    logic [7:0] rgb8,  rgb16,  rgb1;
    logic [3:0] win8,  win16,  win1;
    logic       val8,  val16,  val1;
    logic [1:0] st8,   st16,   st1;

    int n_checks = 0;
    int n_errors = 0;

    logic [12:0] exp8_q[$];
    logic [12:0] exp16_q[$];
    logic [12:0] exp1_q[$];

    logic [7:0] fade_tab [4] = '{8'hFF, 8'h6D, 8'h24, 8'h00};

    layered_objects_mux #(.NUM_LAYERS(8), .TRANSPARENT_RGB(8'hFF), .FRAMES_PER_STEP(FPS)) dut (
        .clk(clk), .resetN(resetN), .layerDrawReq(req[7:0]), .layerRGB(rgb[63:0]),
        .layerEnable(en[7:0]), .bgRGB(bg_rgb), .endRGB(end_rgb), .startOfFrame(sof),
        .gameOver(game_over), .restart(restart), .RGBOut(rgb8), .winLayer(win8),
        .winValid(val8), .screenState(st8));

    layered_objects_mux #(.NUM_LAYERS(16), .TRANSPARENT_RGB(8'hFF), .FRAMES_PER_STEP(FPS)) dut16 (
        .clk(clk), .resetN(resetN), .layerDrawReq(req), .layerRGB(rgb),
        .layerEnable(en), .bgRGB(bg_rgb), .endRGB(end_rgb), .startOfFrame(sof),
        .gameOver(game_over), .restart(restart), .RGBOut(rgb16), .winLayer(win16),
        .winValid(val16), .screenState(st16));

    layered_objects_mux #(.NUM_LAYERS(1), .TRANSPARENT_RGB(8'hFF), .FRAMES_PER_STEP(FPS)) dut1 (
        .clk(clk), .resetN(resetN), .layerDrawReq(req[0:0]), .layerRGB(rgb[7:0]),
        .layerEnable(en[0:0]), .bgRGB(bg_rgb), .endRGB(end_rgb), .startOfFrame(sof),
        .gameOver(game_over), .restart(restart), .RGBOut(rgb1), .winLayer(win1),
        .winValid(val1), .screenState(st1));

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: first layer (top priority) that requests, is enabled and is not the key.
    function automatic logic [12:0] ref_pix(input int n, input logic [15:0] r, input logic [15:0] e,
                                            input logic [127:0] c, input logic [7:0] bg);
        logic [7:0] px;
        for (int i = 0; i < n; i++) begin
            px = c[8*i +: 8];
            if (r[i] && e[i] && px != 8'hFF) return {1'b1, 4'(i), px};
        end
        return {1'b0, 4'd0, bg};
    endfunction

    task automatic clear_layers();
        req = '0;
        en  = '1;
        rgb = {16{8'hFF}};
    endtask

    // Called at a negedge; reset asserts between edges and must act at once.
    task automatic async_reset_pulse(input string tag);
        #2 resetN = 1'b0;
        #1;
        check({tag, "_rgb"},   32'(rgb8),  32'h0);
        check({tag, "_win"},   32'(win8),  32'h0);
        check({tag, "_valid"}, 32'(val8),  32'h0);
        check({tag, "_state"}, 32'(st8),   32'h0);
        check({tag, "_rgb16"}, 32'(rgb16), 32'h0);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_8"},  32'({val8,  win8,  rgb8}),  32'(ref_pix(8,  req, en, rgb, bg_rgb)));
        check({tag, "_16"}, 32'({val16, win16, rgb16}), 32'(ref_pix(16, req, en, rgb, bg_rgb)));
        check({tag, "_1"},  32'({val1,  win1,  rgb1}),  32'(ref_pix(1,  req, en, rgb, bg_rgb)));
    endtask

    // One random PLAY-state pixel: check last cycle's expectations, drive new ones.
    task automatic rand_cycle();
        if (exp8_q.size() > 0) begin
            check("rand_8",  32'({val8,  win8,  rgb8}),  32'(exp8_q.pop_front()));
            check("rand_16", 32'({val16, win16, rgb16}), 32'(exp16_q.pop_front()));
            check("rand_1",  32'({val1,  win1,  rgb1}),  32'(exp1_q.pop_front()));
        end
        check("rand_state", 32'(st8), 32'h0);
        req     = 16'($urandom) & 16'($urandom);
        en      = ~(16'($urandom) & 16'($urandom) & 16'($urandom));
        for (int i = 0; i < 16; i++)
            rgb[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        bg_rgb  = 8'($urandom);
        restart = 1'($urandom);
        sof     = 1'($urandom_range(0, 7) == 0);
        exp8_q.push_back(ref_pix(8, req, en, rgb, bg_rgb));
        exp16_q.push_back(ref_pix(16, req, en, rgb, bg_rgb));
        exp1_q.push_back(ref_pix(1, req, en, rgb, bg_rgb));
        @(negedge clk);
    endtask

    initial begin
        resetN    = 1'b1;
        clear_layers();
        bg_rgb    = 8'h49;
        end_rgb   = 8'h5A;
        sof       = 1'b0;
        game_over = 1'b0;
        restart   = 1'b0;

        // Reset values
        #2 resetN = 1'b0;
        #1;
        check("reset_rgb",   32'(rgb8), 32'h0);
        check("reset_win",   32'(win8), 32'h0);
        check("reset_valid", 32'(val8), 32'h0);
        check("reset_state", 32'(st8),  32'h0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // Priority: layers 2 and 5 hit
        req[2] = 1'b1; rgb[8*2 +: 8] = 8'h1C;
        req[5] = 1'b1; rgb[8*5 +: 8] = 8'hE0;
        @(negedge clk);
        check("prio_rgb",   32'(rgb8), 32'h1C);
        check("prio_win",   32'(win8), 32'h2);
        check("prio_valid", 32'(val8), 32'h1);
        check_all("prio");

        // Layer 2 masked, then keyed transparent
        en[2] = 1'b0;
        @(negedge clk);
        check("mask_rgb", 32'(rgb8), 32'hE0);
        check("mask_win", 32'(win8), 32'h5);
        en[2] = 1'b1; rgb[8*2 +: 8] = 8'hFF;
        @(negedge clk);
        check("key_rgb", 32'(rgb8), 32'hE0);
        check("key_win", 32'(win8), 32'h5);
        check_all("key");

        // No hit -> background
        clear_layers();
        @(negedge clk);
        check("bg_rgb",   32'(rgb8), 32'h49);
        check("bg_valid", 32'(val8), 32'h0);
        check_all("bg");

        // Top and bottom layers of the 16-layer build
        req[0]  = 1'b1; rgb[8*0 +: 8]  = 8'h03;
        req[15] = 1'b1; rgb[8*15 +: 8] = 8'hE3;
        @(negedge clk);
        check("edge_top_win16", 32'(win16), 32'h0);
        check("edge_top_rgb1",  32'(rgb1),  32'h03);
        check_all("edge_top");
        req[0] = 1'b0;
        @(negedge clk);
        check("edge_bot_win16", 32'(win16), 32'hF);
        check("edge_bot_rgb16", 32'(rgb16), 32'hE3);
        check("edge_bot_val1",  32'(val1),  32'h0);
        check_all("edge_bot");

        // Random PLAY stream with an async reset in the middle
        for (int n = 0; n < 150; n++) rand_cycle();
        async_reset_pulse("mid_reset");
        exp8_q.delete(); exp16_q.delete(); exp1_q.delete();
        for (int n = 0; n < 150; n++) rand_cycle();
        exp8_q.delete(); exp16_q.delete(); exp1_q.delete();
        restart = 1'b0;
        sof     = 1'b0;

`ifdef OBJMUX_FADE_EN
        // Fade: gameOver and restart together, SOF on the entry clock is not counted
        clear_layers();
        bg_rgb    = 8'hFF;
        end_rgb   = 8'h5A;
        game_over = 1'b1;
        restart   = 1'b1;
        sof       = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        check("fade_entry_state", 32'(st8),  32'h1);
        check("fade_entry_rgb",   32'(rgb8), 32'hFF);
        @(negedge clk);
        check("fade_lvl0_rgb", 32'(rgb8), 32'hFF);
        for (int k = 1; k <= 4 * FPS; k++) begin
            sof = 1'b1;
            @(negedge clk);
            sof = 1'b0;
            @(negedge clk);
            if (k < 4 * FPS) begin
                check("fade_state", 32'(st8),  32'h1);
                check("fade_rgb",   32'(rgb8), 32'(fade_tab[k / FPS]));
            end else begin
                check("fade_end_state", 32'(st8),  32'h2);
                check("fade_end_rgb",   32'(rgb8), 32'h5A);
                check("fade_end_valid", 32'(val8), 32'h0);
            end
        end
        game_over = 1'b0;
        @(negedge clk);
        check("restart_state", 32'(st8), 32'h0);
        restart = 1'b0;

        // Async reset mid-fade, then a fresh fade restarts at level 0
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        repeat (FPS) begin
            sof = 1'b1;
            @(negedge clk);
            sof = 1'b0;
        end
        @(negedge clk);
        check("fade_lvl1_rgb", 32'(rgb8), 32'h6D);
        async_reset_pulse("fade_reset");
        game_over = 1'b1;
        @(negedge clk);
        check("refade_state", 32'(st8), 32'h1);
        @(negedge clk);
        check("refade_rgb", 32'(rgb8), 32'hFF);
        game_over = 1'b0;
        restart   = 1'b1;
        @(negedge clk);
        check("fade_restart_state", 32'(st8), 32'h0);
        restart = 1'b0;
`else
        // Direct PLAY -> END: state after 1 clk, end pixel after 2
        clear_layers();
        bg_rgb = 8'h49;
        end_rgb = 8'h5A;
        req[2] = 1'b1; rgb[8*2 +: 8] = 8'h1C;
        game_over = 1'b1;
        @(negedge clk);
        check("end_state_n1", 32'(st8),  32'h2);
        check("end_rgb_n1",   32'(rgb8), 32'h1C);
        check("end_valid_n1", 32'(val8), 32'h1);
        @(negedge clk);
        check("end_rgb_n2",   32'(rgb8), 32'h5A);
        check("end_valid_n2", 32'(val8), 32'h0);
        check("end_win_n2",   32'(win8), 32'h0);
        check("end_state16",  32'(st16), 32'h2);
        restart = 1'b1;
        @(negedge clk);
        check("end_prio_state", 32'(st8), 32'h2);
        game_over = 1'b0;
        @(negedge clk);
        check("restart_state", 32'(st8),  32'h0);
        check("restart_rgb",   32'(rgb8), 32'h5A);
        restart = 1'b0;
        @(negedge clk);
        check("play_again_rgb", 32'(rgb8), 32'h1C);
        check("play_again_win", 32'(win8), 32'h2);
        game_over = 1'b1;
        repeat (2) @(negedge clk);
        game_over = 1'b0;
        check("end_hold_rgb", 32'(rgb8), 32'h5A);
        async_reset_pulse("end_reset");
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
